// File: rtl/bcd_countdown.sv
// bcd_countdown: two-digit BCD down-counter with start/pause/clear control, done pulse and expired flag
module bcd_countdown #(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_units,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       running,
    output logic       expired,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;
    state_t     state, state_nx;
    logic [3:0] tens_nx, units_nx, rl_tens, rl_units, rl_tens_nx, rl_units_nx, ld_tens, ld_units;
    logic       done_nx;
    assign ld_tens  = load_tens  > 4'd9 ? 4'd9 : load_tens;
    assign ld_units = load_units > 4'd9 ? 4'd9 : load_units;
    always_comb begin
        state_nx    = state;
        tens_nx     = tens;
        units_nx    = units;
        rl_tens_nx  = rl_tens;
        rl_units_nx = rl_units;
        done_nx     = 1'b0;
        if (clear) begin
            state_nx = IDLE;
            tens_nx  = 4'd0;
            units_nx = 4'd0;
        end else if (start) begin
            tens_nx     = ld_tens;
            units_nx    = ld_units;
            rl_tens_nx  = ld_tens;
            rl_units_nx = ld_units;
            state_nx    = (ld_tens == 4'd0 && ld_units == 4'd0) ? EXPIRED : RUN;
            done_nx     = (ld_tens == 4'd0 && ld_units == 4'd0);
        end else begin
            case (state)
                RUN: begin
                    if (pause) begin
                        state_nx = PAUSED;
                    end else if (tick) begin
                        units_nx = units == 4'd0 ? 4'd9 : units - 4'd1;
                        tens_nx  = units == 4'd0 ? tens - 4'd1 : tens;
                        state_nx = (tens == 4'd0 && units == 4'd1) ? EXPIRED : RUN;
                        done_nx  = (tens == 4'd0 && units == 4'd1);
                    end
                end
                PAUSED: state_nx = pause ? RUN : PAUSED;
                EXPIRED: begin
                    // a 00 reload value would only re-expire, so it keeps the block parked here
                    if (AUTO_RELOAD && tick && (rl_tens != 4'd0 || rl_units != 4'd0)) begin
                        state_nx = RUN;
                        tens_nx  = rl_tens;
                        units_nx = rl_units;
                    end
                end
                default: state_nx = state;
            endcase
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            tens     <= 4'd0;
            units    <= 4'd0;
            rl_tens  <= 4'd0;
            rl_units <= 4'd0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            tens     <= tens_nx;
            units    <= units_nx;
            rl_tens  <= rl_tens_nx;
            rl_units <= rl_units_nx;
            done     <= done_nx;
        end
    end
    assign running = (state == RUN);
    assign expired = (state == EXPIRED);
endmodule

// File: tb/tb_bcd_countdown.sv
// tb_bcd_countdown: directed-vector bench for bcd_countdown, with and without auto-reload
module tb_bcd_countdown;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
    logic [3:0] load_tens = 4'd0, load_units = 4'd0;
    logic [3:0] t0, u0, t1, u1;
    logic       r0, e0, d0, r1, e1, d1;
    logic [10:0] obs, exp_v;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bcd_countdown #(.AUTO_RELOAD(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .tick(tick), .start(start), .pause(pause), .clear(clear),
        .load_tens(load_tens), .load_units(load_units),
        .tens(t0), .units(u0), .running(r0), .expired(e0), .done(d0)
    );
    bcd_countdown #(.AUTO_RELOAD(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .tick(tick), .start(start), .pause(pause), .clear(clear),
        .load_tens(load_tens), .load_units(load_units),
        .tens(t1), .units(u1), .running(r1), .expired(e1), .done(d1)
    );

    // observation vector layout: {tens, units, running, expired, done}
    task automatic step(input logic t, input logic s, input logic p, input logic c);
        tick = t; start = s; pause = p; clear = c;
        @(posedge clk);
        #1;
        tick = 0; start = 0; pause = 0; clear = 0;
    endtask

    task automatic load(input logic [3:0] lt, input logic [3:0] lu);
        load_tens = lt; load_units = lu;
        step(0, 1, 0, 0);
    endtask

    task automatic test_reset;
        #3;
        obs = {t0, u0, r0, e0, d0};
        if (obs !== 11'h000) begin $display("FAIL reset obs=%h exp=%h", obs, 11'h000); n_err++; end
        n_vec++;
        @(negedge clk);
        reset_n = 1'b1;
        step(1, 0, 1, 0);
        obs = {t0, u0, r0, e0, d0};
        if (obs !== 11'h000) begin $display("FAIL idle_ignore obs=%h exp=%h", obs, 11'h000); n_err++; end
        n_vec++;
    endtask

    task automatic test_count12;
        load(4'd1, 4'd2);
        obs = {t0, u0, r0, e0, d0};
        exp_v = {4'd1, 4'd2, 3'b100};
        if (obs !== exp_v) begin $display("FAIL load12 obs=%h exp=%h", obs, exp_v); n_err++; end
        n_vec++;
        for (int v = 11; v >= 0; v--) begin
            step(1, 0, 0, 0);
            obs = {t0, u0, r0, e0, d0};
            exp_v = {4'(v / 10), 4'(v % 10), v != 0, v == 0, v == 0};
            if (obs !== exp_v) begin $display("FAIL count12 v=%0d obs=%h exp=%h", v, obs, exp_v); n_err++; end
            n_vec++;
        end
        step(0, 0, 0, 0);
        obs = {t0, u0, r0, e0, d0};
        exp_v = {8'h00, 3'b010};
        if (obs !== exp_v) begin $display("FAIL done_once obs=%h exp=%h", obs, exp_v); n_err++; end
        n_vec++;
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0);
            obs = {t0, u0, r0, e0, d0};
            if (obs !== exp_v) begin $display("FAIL hold00 i=%0d obs=%h exp=%h", i, obs, exp_v); n_err++; end
            n_vec++;
        end
    endtask

    task automatic test_wrap_clamp;
        load(4'd2, 4'd0);
        step(1, 0, 0, 0);
        obs = {t0, u0, r0, e0, d0};
        exp_v = {4'd1, 4'd9, 3'b100};
        if (obs !== exp_v) begin $display("FAIL wrap20 obs=%h exp=%h", obs, exp_v); n_err++; end
        n_vec++;
        load(4'hA, 4'hF);
        obs = {t0, u0, r0, e0, d0};
        exp_v = {4'd9, 4'd9, 3'b100};
        if (obs !== exp_v) begin $display("FAIL clamp obs=%h exp=%h", obs, exp_v); n_err++; end
        n_vec++;
    endtask

    task automatic test_pause;
        load(4'd0, 4'd5);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        obs = {t0, u0, r0, e0, d0};
        exp_v = {4'd0, 4'd3, 3'b000};
        if (obs !== exp_v) begin $display("FAIL pause obs=%h exp=%h", obs, exp_v); n_err++; end
        n_vec++;
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        obs = {t0, u0, r0, e0, d0};
        if (obs !== exp_v) begin $display("FAIL paused_hold obs=%h exp=%h", obs, exp_v); n_err++; end
        n_vec++;
        step(1, 0, 1, 0);
        obs = {t0, u0, r0, e0, d0};
        exp_v = {4'd0, 4'd3, 3'b100};
        if (obs !== exp_v) begin $display("FAIL resume obs=%h exp=%h", obs, exp_v); n_err++; end
        n_vec++;
        step(1, 0, 0, 0);
        obs = {t0, u0, r0, e0, d0};
        exp_v = {4'd0, 4'd2, 3'b100};
        if (obs !== exp_v) begin $display("FAIL resume_tick obs=%h exp=%h", obs, exp_v); n_err++; end
        n_vec++;
    endtask

    task automatic test_zero_load;
        load(4'd0, 4'd0);
        obs = {t0, u0, r0, e0, d0};
        exp_v = {8'h00, 3'b011};
        if (obs !== exp_v) begin $display("FAIL zero_load obs=%h exp=%h", obs, exp_v); n_err++; end
        n_vec++;
        step(0, 0, 0, 0);
        obs = {t0, u0, r0, e0, d0};
        exp_v = {8'h00, 3'b010};
        if (obs !== exp_v) begin $display("FAIL zero_done_once obs=%h exp=%h", obs, exp_v); n_err++; end
        n_vec++;
        step(0, 0, 0, 1);
        obs = {t0, u0, r0, e0, d0};
        if (obs !== 11'h000) begin $display("FAIL zero_clear obs=%h exp=%h", obs, 11'h000); n_err++; end
        n_vec++;
    endtask

    task automatic test_auto_reload;
        load(4'd0, 4'd2);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        obs = {t1, u1, r1, e1, d1};
        exp_v = {8'h00, 3'b011};
        if (obs !== exp_v) begin $display("FAIL ar_expire obs=%h exp=%h", obs, exp_v); n_err++; end
        n_vec++;
        step(1, 0, 0, 0);
        obs = {t1, u1, r1, e1, d1};
        exp_v = {4'd0, 4'd2, 3'b100};
        if (obs !== exp_v) begin $display("FAIL ar_reload obs=%h exp=%h", obs, exp_v); n_err++; end
        n_vec++;
        obs = {t0, u0, r0, e0, d0};
        exp_v = {8'h00, 3'b010};
        if (obs !== exp_v) begin $display("FAIL no_ar_hold obs=%h exp=%h", obs, exp_v); n_err++; end
        n_vec++;
        load_tens = 4'd5; load_units = 4'd5;
        step(0, 1, 0, 1);
        obs = {t1, u1, r1, e1, d1};
        if (obs !== 11'h000) begin $display("FAIL clear_wins obs=%h exp=%h", obs, 11'h000); n_err++; end
        n_vec++;
    endtask

    task automatic test_async_reset;
        load(4'd3, 4'd7);
        obs = {t0, u0, r0, e0, d0};
        exp_v = {4'd3, 4'd7, 3'b100};
        if (obs !== exp_v) begin $display("FAIL load37 obs=%h exp=%h", obs, exp_v); n_err++; end
        n_vec++;
        #2 reset_n = 1'b0;
        #1;
        obs = {t0, u0, r0, e0, d0};
        if (obs !== 11'h000) begin $display("FAIL async_reset obs=%h exp=%h", obs, 11'h000); n_err++; end
        n_vec++;
        @(negedge clk);
        reset_n = 1'b1;
        step(1, 0, 0, 0);
        obs = {t0, u0, r0, e0, d0};
        if (obs !== 11'h000) begin $display("FAIL post_reset_tick obs=%h exp=%h", obs, 11'h000); n_err++; end
        n_vec++;
    endtask

    initial begin
        test_reset;
        test_count12;
        test_wrap_clamp;
        test_pause;
        test_zero_load;
        test_auto_reload;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
